// File: rtl/countdown_timer_if.sv
// Countdown timer control/status bundle.
//   load         : single-cycle pulse, capture load_value
//   load_value   : start value in seconds
//   start_pause  : single-cycle pulse, start / pause / resume
//   seconds_left : remaining seconds (registered)
//   running      : high while counting
//   expired      : expiry indication
// master drives the controls and observes status; slave is the timer.
interface countdown_timer_if #(
  parameter int unsigned SECONDS_WIDTH = 8
);
  logic                     load;
  logic [SECONDS_WIDTH-1:0] load_value;
  logic                     start_pause;
  logic [SECONDS_WIDTH-1:0] seconds_left;
  logic                     running;
  logic                     expired;

  modport master (
    output load, load_value, start_pause,
    input  seconds_left, running, expired
  );

  modport slave (
    input  load, load_value, start_pause,
    output seconds_left, running, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// Seconds countdown timer.
// Loads a start value, decrements it once every TICKS_PER_SECOND clk cycles
// while running and flags expiry on reaching zero. start_pause toggles
// running/paused; load (priority over start_pause) returns to idle.
// Ports:
//   clk         : system clock, rising edge
//   async_reset : asynchronous, active-low reset
//   bus         : countdown_timer_if.slave (load, load_value, start_pause,
//                 seconds_left, running, expired)
// Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN
//   defined   -> on reaching zero, reload from the last loaded value and keep
//                running; expired becomes a one-cycle pulse. A zero reload
//                value still enters the latched expired state.
//   undefined -> expired is latched until load or reset.
module countdown_timer #(
  parameter int unsigned SECONDS_WIDTH    = 8,
  parameter int unsigned TICKS_PER_SECOND = 50000000
) (
  input  logic              clk,
  input  logic              async_reset,
  countdown_timer_if.slave  bus
);

  localparam int unsigned PRESC_WIDTH = $clog2(TICKS_PER_SECOND);
  localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = PRESC_WIDTH'(TICKS_PER_SECOND - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED,
    EXPIRED
  } state_t;

  state_t                   state_q, state_d;
  logic [PRESC_WIDTH-1:0]   presc_q, presc_d;
  logic [SECONDS_WIDTH-1:0] seconds_q, seconds_d;
  logic                     second_done;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [SECONDS_WIDTH-1:0] reload_q, reload_d;
  logic                     pulse_q, pulse_d;
`endif

  assign second_done = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      seconds_q <= '0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= '0;
      pulse_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      seconds_q <= seconds_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= reload_d;
      pulse_q   <= pulse_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    seconds_d = seconds_q;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d  = reload_q;
    pulse_d   = 1'b0;
`endif
    if (bus.load) begin
      state_d   = IDLE;
      presc_d   = '0;
      seconds_d = bus.load_value;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_d  = bus.load_value;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_pause && (seconds_q != '0)) begin
            state_d = RUNNING;
            presc_d = '0;
          end
        end
        RUNNING: begin
          if (second_done) begin
            // The terminal tick is consumed even when a pause arrives with it.
            presc_d = '0;
            if (seconds_q == SECONDS_WIDTH'(1)) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
              if (reload_q != '0) begin
                seconds_d = reload_q;
                pulse_d   = 1'b1;
                state_d   = bus.start_pause ? PAUSED : RUNNING;
              end else begin
                seconds_d = '0;
                state_d   = EXPIRED;
              end
`else
              seconds_d = '0;
              state_d   = EXPIRED;
`endif
            end else begin
              seconds_d = seconds_q - SECONDS_WIDTH'(1);
              if (bus.start_pause) state_d = PAUSED;
            end
          end else if (bus.start_pause) begin
            // Pause freezes the prescaler at its current value.
            state_d = PAUSED;
          end else begin
            presc_d = presc_q + PRESC_WIDTH'(1);
          end
        end
        PAUSED: begin
          if (bus.start_pause) state_d = RUNNING;
        end
        EXPIRED: begin
          seconds_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.seconds_left = seconds_q;
  assign bus.running      = (state_q == RUNNING);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  assign bus.expired      = (state_q == EXPIRED) | pulse_q;
`else
  assign bus.expired      = (state_q == EXPIRED);
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with fixed
// expectations plus randomized load/start_pause traffic, all checked against
// a cycle-level behavioural model of the seconds countdown.
module tb_countdown_timer;

  localparam int unsigned TPS = 4;
  localparam int unsigned SW  = 8;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic async_reset = 1'b0;

  countdown_timer_if #(.SECONDS_WIDTH(SW)) bus ();

  countdown_timer #(
    .SECONDS_WIDTH   (SW),
    .TICKS_PER_SECOND(TPS)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: remaining seconds, cycles elapsed within the current
  // second, and simple activity flags.
  int m_rem, m_sub, m_reload;
  bit m_run, m_paused, m_done, m_pulse;

  task automatic check_eq(input string tag, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_rem = 0; m_sub = 0; m_reload = 0;
    m_run = 0; m_paused = 0; m_done = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(input bit ld, input int lv, input bit sp);
    int nxt;
    m_pulse = 0;
    if (ld) begin
      m_rem = lv; m_reload = lv; m_sub = 0;
      m_run = 0; m_paused = 0; m_done = 0;
    end else if (m_done) begin
      // expired: only load/reset leave
    end else if (m_run) begin
      nxt = (m_sub + 1) % TPS;
      if (nxt == 0) begin
        m_sub = 0;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (AUTO_RELOAD && m_reload > 0) begin
            m_rem = m_reload;
            m_pulse = 1;
          end else begin
            m_done = 1;
            m_run = 0;
          end
        end
      end else if (!sp) begin
        m_sub = nxt;
      end
      if (sp && !m_done) begin
        m_run = 0;
        m_paused = 1;
      end
    end else if (m_paused) begin
      if (sp) begin
        m_run = 1;
        m_paused = 0;
      end
    end else if (sp && m_rem > 0) begin
      m_run = 1;
    end
  endfunction

  task automatic check_model(input string tag);
    check_eq({tag, "_sec"}, int'(bus.seconds_left), m_rem);
    check_eq({tag, "_run"}, int'(bus.running), int'(m_run));
    check_eq({tag, "_exp"}, int'(bus.expired), int'(m_done | m_pulse));
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1ns later.
  task automatic step(input bit ld, input int lv, input bit sp, input string tag);
    bus.load        = ld;
    bus.load_value  = lv[SW-1:0];
    bus.start_pause = sp;
    @(posedge clk);
    model_step(ld, lv, sp);
    #1;
    bus.load        = 1'b0;
    bus.start_pause = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    async_reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    async_reset = 1'b1;
  endtask

  int exp_sec;

  initial begin
    bus.load        = 1'b0;
    bus.load_value  = '0;
    bus.start_pause = 1'b0;
    do_reset();

    // Directed: load 3, start, count down to zero.
    step(1, 3, 0, "t1_load");
    step(0, 0, 1, "t1_start");
    for (int k = 1; k <= 14; k++) begin
      step(0, 0, 0, "t1");
      if (!AUTO_RELOAD) begin
        exp_sec = (k >= 12) ? 0 : 3 - k / 4;
        check_eq("t1_const_sec", int'(bus.seconds_left), exp_sec);
        check_eq("t1_const_exp", int'(bus.expired), (k >= 12) ? 1 : 0);
      end
    end
    step(0, 0, 1, "t1_late_start");
    if (!AUTO_RELOAD) check_eq("t1_late_exp", int'(bus.expired), 1);

    // Directed: pause mid-second, hold, resume from held prescaler.
    step(1, 5, 0, "t2_load");
    step(0, 0, 1, "t2_start");
    repeat (6) step(0, 0, 0, "t2_run");
    step(0, 0, 1, "t2_pause");
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, "t2_hold");
      check_eq("t2_hold_sec", int'(bus.seconds_left), 4);
    end
    step(0, 0, 1, "t2_resume");
    step(0, 0, 0, "t2_r1");
    check_eq("t2_r1_sec", int'(bus.seconds_left), 4);
    step(0, 0, 0, "t2_r2");
    check_eq("t2_r2_sec", int'(bus.seconds_left), 3);

    // Directed: zero load ignores start; load beats start_pause.
    step(1, 0, 0, "t3_load0");
    step(0, 0, 1, "t3_start0");
    check_eq("t3_idle_run", int'(bus.running), 0);
    step(1, 2, 1, "t3_both");
    check_eq("t3_both_sec", int'(bus.seconds_left), 2);
    check_eq("t3_both_run", int'(bus.running), 0);
    step(0, 0, 0, "t3_after");

    // Directed: reload while running restarts the second.
    step(1, 7, 0, "t4_load7");
    step(0, 0, 1, "t4_start");
    repeat (2) step(0, 0, 0, "t4_run");
    step(1, 9, 0, "t4_load9");
    check_eq("t4_sec9", int'(bus.seconds_left), 9);
    check_eq("t4_run0", int'(bus.running), 0);
    step(0, 0, 1, "t4_start2");
    repeat (TPS - 1) step(0, 0, 0, "t4_wait");
    check_eq("t4_before", int'(bus.seconds_left), 9);
    step(0, 0, 0, "t4_tick");
    check_eq("t4_tick_sec", int'(bus.seconds_left), 8);

    // Directed: asynchronous reset mid-count.
    step(1, 5, 0, "t5_load");
    step(0, 0, 1, "t5_start");
    repeat (6) step(0, 0, 0, "t5_run");
    #2;
    async_reset = 1'b0;
    model_reset();
    #1;
    check_model("t5_async");
    @(negedge clk);
    async_reset = 1'b1;
    step(0, 0, 1, "t5_start_after");
    check_eq("t5_run_after", int'(bus.running), 0);

    // Directed: auto-reload cycling (only meaningful with the feature).
    if (AUTO_RELOAD) begin
      step(1, 2, 0, "t6_load");
      step(0, 0, 1, "t6_start");
      for (int k = 1; k <= 24; k++) begin
        step(0, 0, 0, "t6");
        check_eq("t6_const_sec", int'(bus.seconds_left), ((k / 4) % 2 == 0) ? 2 : 1);
        check_eq("t6_const_exp", int'(bus.expired), (k % 8 == 0) ? 1 : 0);
        check_eq("t6_const_run", int'(bus.running), 1);
      end
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit ld, sp;
      int lv;
      ld = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 5) == 0);
      lv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      step(ld, lv, sp, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Seconds countdown timer: loads a start value, decrements it once per second of clk while running, and flags expiry on reaching zero. Single start/pause pulse input toggles running/paused. Sits beside the up-counting stopwatch on the DE0 top level; seconds_left feeds the same 7-segment display path.

Parameters:
SECONDS_WIDTH, 8, width of load_value and seconds_left.
TICKS_PER_SECOND, 50000000, clk cycles per decrement; must be >= 2. Prescaler width is $clog2(TICKS_PER_SECOND).

Ports:
clk  input  1  system clock, rising edge.
async_reset  input  1  asynchronous, active-low reset.
load  input  1  single-cycle pulse: capture load_value.
load_value  input  SECONDS_WIDTH  start value in seconds.
start_pause  input  1  single-cycle pulse, already debounced/edge-detected: start, pause or resume.
seconds_left  output  SECONDS_WIDTH  current remaining seconds, registered.
running  output  1  high while in RUNNING.
expired  output  1  expiry indication (level; pulse when AUTO_RELOAD_EN is defined).

Behaviour:
- Reset (async_reset low, any time including mid-count): state IDLE, prescaler 0, seconds_left 0, reload register 0, running 0, expired 0.
- States: IDLE, RUNNING, PAUSED, EXPIRED; registered state, combinational next-state.
- load has priority over start_pause in the same cycle. In any state, load sets seconds_left = load_value, reload register = load_value, prescaler = 0, expired = 0, next state IDLE. All effects are visible the cycle after the pulse.
- IDLE: start_pause with seconds_left != 0 -> RUNNING. Prescaler starts at 0. start_pause with seconds_left == 0 is ignored and the state stays IDLE.
- RUNNING: prescaler increments every cycle. When prescaler == TICKS_PER_SECOND-1, the prescaler clears to 0 and seconds_left decrements by 1.
  - A decrement from 1 to 0 enters EXPIRED on the same edge.
  - The first decrement happens exactly TICKS_PER_SECOND cycles after entering RUNNING.
- RUNNING + start_pause -> PAUSED. The prescaler value is held, not cleared.
  - If start_pause coincides with the terminal prescaler tick, the decrement still happens. If that decrement reaches 0, EXPIRED wins over PAUSED.
- PAUSED: prescaler and seconds_left are frozen. start_pause -> RUNNING, and counting resumes from the held prescaler value.
- EXPIRED: expired = 1 and seconds_left = 0. start_pause is ignored. Only load or reset leaves this state.
- running = (state == RUNNING). expired = (state == EXPIRED). Both are registered or decoded from the state register, with no combinational path from inputs.
- seconds_left never wraps below 0. No decrement occurs outside RUNNING.

Optional Feature:
Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN.
- Defined: on the 1->0 decrement in RUNNING, seconds_left reloads from the reload register, the prescaler clears, and the state stays RUNNING.
  - expired pulses high for exactly one cycle, on the cycle after the reload edge.
  - If the reload register is 0, the block behaves as without the macro and enters EXPIRED.
  - start_pause on the reload cycle -> PAUSED with the reloaded value.
- Not defined: behaviour is as specified above, with EXPIRED latched until load or reset.

Test Plan:
1. TICKS_PER_SECOND=4. Reset, load 3, start_pause -> seconds_left goes 3,2,1,0 at cycles 4, 8 and 12 after start. expired=1 and running=0 from cycle 12 onward. A later start_pause has no effect.
2. TICKS_PER_SECOND=4, load 5, start. Pause at cycle 6, hold 10 cycles, resume -> seconds_left stays 4 while paused. It reaches 3 exactly 2 cycles after resume (prescaler held at 2).
3. Load 0, start_pause -> state stays IDLE, running=0, expired=0. Then load 2 and start_pause in the same cycle -> load wins: seconds_left=2, IDLE, running=0.
4. While RUNNING with seconds_left=7, pulse load with value 9 -> next cycle seconds_left=9, IDLE, prescaler 0. After start_pause, the first decrement comes TICKS_PER_SECOND cycles later.
5. async_reset low mid-count (seconds_left=4, prescaler=2), asynchronous to clk -> all outputs 0 immediately, state IDLE. After release, start_pause is ignored because seconds_left is 0.
6. With COUNTDOWN_TIMER_AUTO_RELOAD_EN, TICKS_PER_SECOND=4, load 2, start -> sequence 2,1,2,1,... expired is a one-cycle pulse every 8 cycles and running stays 1.
